pll_lock_sequencer: RTL and testbench

//  Sequences the Gowin PLLVR at power-up: pulses PLL RESET, waits for LOCK,

---
 rtl/pll_seq_pkg.sv | 28 ++
 rtl/pll_lock_sequencer_sync_2ff.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 127 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and 27 MHz timing defaults for the PLLVR lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAIL
   } state_t;

   localparam int unsigned DEF_PLL_RST_CYCLES      = 27;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 270000;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 2700;
   localparam int unsigned DEF_MAX_RETRIES         = 3;

   function automatic int unsigned max3(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 2) ? m : 2;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous PLL LOCK input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up sequencer for the PLLVR: reset pulse, lock wait, lock
// qualification, bounded retries and downstream reset release.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
   localparam int unsigned RW =
      (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic          clkin,
   input  logic          reset,
   input  logic          pll_lock,
   input  logic          soft_relock,
   output logic          pll_reset,
   output logic          sys_rst,
   output logic          pll_ready,
   output logic          pll_fail,
   output logic          lock_lost,
   output logic [RW-1:0] retry_cnt
);

   localparam int unsigned CW = $clog2(max3(PLL_RST_CYCLES,
      LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));

   localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

   logic          lock_s;
   state_t        state;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic [RW-1:0] retry_nxt;
   logic          lost_nxt;

   sync_2ff u_sync (
      .clk (clkin),
      .rst (reset),
      .d   (pll_lock),
      .q   (lock_s)
   );

   always_comb begin
      nxt       = state;
      retry_nxt = retry_cnt;
      lost_nxt  = 1'b0;
      unique case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               nxt = STABILIZE;
            end else if (cnt == TMO_LAST) begin
               if (retry_cnt == RETRY_MAX) begin
                  nxt = FAIL;
               end else begin
                  retry_nxt = retry_cnt + RW'(1);
                  nxt       = RESET_PLL;
               end
            end
         end
         STABILIZE: begin
            // A lock dropout during qualification counts as a failed attempt
            if (!lock_s) begin
               if (retry_cnt == RETRY_MAX) begin
                  nxt = FAIL;
               end else begin
                  retry_nxt = retry_cnt + RW'(1);
                  nxt       = RESET_PLL;
               end
            end else if (cnt == STB_LAST) begin
               nxt = RUN;
            end
         end
         RUN: begin
            if (!lock_s) begin
               lost_nxt  = 1'b1;
               retry_nxt = '0;
               nxt       = RESET_PLL;
            end else if (soft_relock) begin
               retry_nxt = '0;
               nxt       = RESET_PLL;
            end
         end
         FAIL: begin
            if (soft_relock) begin
               retry_nxt = '0;
               nxt       = RESET_PLL;
            end
         end
         default: begin
            nxt       = RESET_PLL;
            retry_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         sys_rst   <= 1'b1;
         pll_ready <= 1'b0;
         pll_fail  <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state     <= nxt;
         retry_cnt <= retry_nxt;
         lock_lost <= lost_nxt;
         if (nxt != state || nxt == RUN || nxt == FAIL) cnt <= '0;
         else cnt <= cnt + CW'(1);
         // Outputs follow the state being entered, so they switch with it
         pll_reset <= (nxt == RESET_PLL) || (nxt == FAIL);
         sys_rst   <= (nxt != RUN);
         pll_ready <= (nxt == RUN);
         pll_fail  <= (nxt == FAIL);
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with shortened timing.
module tb_pll_lock_sequencer;

   localparam int PR = 4;
   localparam int TO = 32;
   localparam int ST = 8;
   localparam int MR = 2;

   localparam int S_PR  = 0;
   localparam int S_SR  = 1;
   localparam int S_RDY = 2;
   localparam int S_FL  = 3;
   localparam int S_LL  = 4;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock = 1'b0;
   logic       soft_relock = 1'b0;
   logic       pll_reset, sys_rst, pll_ready, pll_fail, lock_lost;
   logic [1:0] retry_cnt;

   int edge_n = 0;
   int n_run = 0;
   int n_fail = 0;
   bit low_seen = 1'b0;

   typedef struct {
      string name;
      int    val;
   } exp_t;

   exp_t sb[$];

   pll_lock_sequencer #(
      .PLL_RST_CYCLES      (PR),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (ST),
      .MAX_RETRIES         (MR)
   ) dut (
      .clkin       (clkin),
      .reset       (reset),
      .pll_lock    (pll_lock),
      .soft_relock (soft_relock),
      .pll_reset   (pll_reset),
      .sys_rst     (sys_rst),
      .pll_ready   (pll_ready),
      .pll_fail    (pll_fail),
      .lock_lost   (lock_lost),
      .retry_cnt   (retry_cnt)
   );

   always #5 clkin = ~clkin;

   always @(posedge clkin) edge_n <= edge_n + 1;

   always @(negedge clkin) if (sys_rst === 1'b0) low_seen = 1'b1;

   function automatic logic sig(input int w);
      case (w)
         S_PR:    return pll_reset;
         S_SR:    return sys_rst;
         S_RDY:   return pll_ready;
         S_FL:    return pll_fail;
         default: return lock_lost;
      endcase
   endfunction

   function automatic int outs();
      logic [6:0] v;
      v = {pll_reset, sys_rst, pll_ready, pll_fail, lock_lost, retry_cnt};
      return int'(v);
   endfunction

   task automatic wait_sig(input int w, input logic v,
                           input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit && at < 0; i++) begin
         @(negedge clkin);
         if (sig(w) === v) at = edge_n;
      end
   endtask

   task automatic do_reset(output int n0);
      @(negedge clkin);
      reset = 1'b1;
      pll_lock = 1'b0;
      soft_relock = 1'b0;
      repeat (2) @(negedge clkin);
      reset = 1'b0;
      n0 = edge_n;
   endtask

   task automatic go_run;
      int n0, at;
      do_reset(n0);
      pll_lock = 1'b1;
      wait_sig(S_RDY, 1'b1, 100, at);
   endtask

   task automatic test_reset;
      exp_t e;
      sb.push_back(exp_t'{"reset_outs", 7'b1100000});
      #12;
      e = sb.pop_front(); n_run++;
      if (outs() !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, outs(), e.val);
      end
   endtask

   task automatic test_release;
      int n0, at, k, v;
      exp_t e;
      do_reset(n0);
      sb.push_back(exp_t'{"rst_pulse_end", n0 + PR});
      wait_sig(S_PR, 1'b0, 50, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      repeat (5) @(negedge clkin);
      pll_lock = 1'b1;
      k = edge_n + 1;
      sb.push_back(exp_t'{"sys_rst_fall", k + 2 + ST});
      sb.push_back(exp_t'{"ready_rise", k + 2 + ST});
      sb.push_back(exp_t'{"retry_run", 0});
      wait_sig(S_SR, 1'b0, 50, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = (pll_ready === 1'b1) ? edge_n : -1;
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      v = int'(retry_cnt);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
   endtask

   task automatic test_lock_loss;
      int j, at, v;
      exp_t e;
      @(negedge clkin);
      pll_lock = 1'b0;
      j = edge_n + 1;
      sb.push_back(exp_t'{"lock_lost_edge", j + 2});
      sb.push_back(exp_t'{"loss_outs", 4'b1100});
      sb.push_back(exp_t'{"lock_lost_width", 0});
      wait_sig(S_LL, 1'b1, 10, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = int'({pll_reset, sys_rst, pll_ready, retry_cnt != 2'd0});
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      @(negedge clkin);
      v = int'(lock_lost);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
   endtask

   task automatic test_relock_ignored;
      int at, f;
      exp_t e;
      wait_sig(S_PR, 1'b0, 20, f);
      sb.push_back(exp_t'{"wait_timeout_rise", f + TO});
      @(negedge clkin);
      soft_relock = 1'b1;
      @(negedge clkin);
      soft_relock = 1'b0;
      wait_sig(S_PR, 1'b1, 50, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val || f < 0) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
   endtask

   task automatic test_timeout;
      int n0, at, v;
      exp_t e;
      do_reset(n0);
      for (int a = 0; a < 3; a++) begin
         sb.push_back(exp_t'{"pr_fall", n0 + PR + a * (PR + TO)});
         if (a < 2) sb.push_back(exp_t'{"pr_rise", n0 + (a + 1) * (PR + TO)});
      end
      sb.push_back(exp_t'{"fail_rise", n0 + 3 * (PR + TO)});
      sb.push_back(exp_t'{"fail_retry", MR});
      sb.push_back(exp_t'{"fail_hold", 2'b11});
      for (int a = 0; a < 3; a++) begin
         wait_sig(S_PR, 1'b0, 50, at);
         e = sb.pop_front(); n_run++;
         if (at !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
         end
         if (a < 2) begin
            wait_sig(S_PR, 1'b1, 50, at);
            e = sb.pop_front(); n_run++;
            if (at !== e.val) begin
               n_fail++;
               $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
            end
         end
      end
      wait_sig(S_FL, 1'b1, 50, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = int'(retry_cnt);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      repeat (10) @(negedge clkin);
      v = int'({pll_reset, pll_fail});
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
   endtask

   task automatic test_fail_relock;
      int f, at, v;
      exp_t e;
      @(negedge clkin);
      f = edge_n;
      soft_relock = 1'b1;
      pll_lock = 1'b1;
      sb.push_back(exp_t'{"fail_fall", f + 1});
      sb.push_back(exp_t'{"relock_retry", 0});
      sb.push_back(exp_t'{"relock_pr_fall", f + 1 + PR});
      sb.push_back(exp_t'{"relock_ready", f + 1 + PR + 1 + ST});
      wait_sig(S_FL, 1'b0, 5, at);
      soft_relock = 1'b0;
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = int'(retry_cnt);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      wait_sig(S_PR, 1'b0, 20, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      wait_sig(S_RDY, 1'b1, 40, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
   endtask

   task automatic test_stab_glitch;
      int n0, g, at, v;
      exp_t e;
      do_reset(n0);
      pll_lock = 1'b1;
      low_seen = 1'b0;
      wait_sig(S_PR, 1'b0, 20, at);
      @(negedge clkin);
      g = edge_n;
      pll_lock = 1'b0;
      sb.push_back(exp_t'{"glitch_pr_rise", g + 3});
      sb.push_back(exp_t'{"glitch_retry", 1});
      sb.push_back(exp_t'{"glitch_pr_fall", g + 3 + PR});
      sb.push_back(exp_t'{"glitch_sys_rst_low", 0});
      sb.push_back(exp_t'{"glitch_ready", g + 3 + PR + 1 + ST});
      @(negedge clkin);
      pll_lock = 1'b1;
      wait_sig(S_PR, 1'b1, 20, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = int'(retry_cnt);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      wait_sig(S_PR, 1'b0, 20, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
      v = int'(low_seen);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, v, e.val);
      end
      wait_sig(S_RDY, 1'b1, 40, at);
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
   endtask

   task automatic test_async_reset;
      exp_t e;
      sb.push_back(exp_t'{"async_reset_outs", 7'b1100000});
      @(posedge clkin);
      #2 reset = 1'b1;
      #1;
      e = sb.pop_front(); n_run++;
      if (outs() !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, outs(), e.val);
      end
      @(negedge clkin);
      reset = 1'b0;
   endtask

   task automatic test_lost_and_relock;
      int j0, at;
      exp_t e;
      go_run();
      @(negedge clkin);
      j0 = edge_n;
      pll_lock = 1'b0;
      sb.push_back(exp_t'{"same_cycle_lock_lost", j0 + 3});
      repeat (2) @(negedge clkin);
      soft_relock = 1'b1;
      wait_sig(S_LL, 1'b1, 5, at);
      soft_relock = 1'b0;
      e = sb.pop_front(); n_run++;
      if (at !== e.val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", e.name, at, e.val);
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_lock_loss();
      test_relock_ignored();
      test_timeout();
      test_fail_relock();
      test_stab_glitch();
      test_async_reset();
      test_lost_and_relock();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
